// File: rtl/ula_pkg.sv
// ============================================================================
// Module      : ula_pkg
// Description : ULA opcodes and multiply-sequencer state encoding.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ula_pkg;

    localparam logic [1:0] ULA_ADD    = 2'b00;
    localparam logic [1:0] ULA_SUB    = 2'b01;
    localparam logic [1:0] ULA_AND    = 2'b10;
    localparam logic [1:0] ULA_BARREL = 2'b11;

    typedef logic [1:0] mul_state_t;

    localparam mul_state_t ST_IDLE  = 2'd0;
    localparam mul_state_t ST_ADD   = 2'd1;
    localparam mul_state_t ST_SHIFT = 2'd2;
    localparam mul_state_t ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ula_mul_seq.sv
// ============================================================================
// Module      : ula_mul_seq
// Description : Shift-and-add unsigned multiplier that borrows the shared ULA
//               and barrel shifter, with a start/done handshake.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ula_mul_seq
    import ula_pkg::*;
#(
    parameter int W   = 16,
    parameter int SHW = 4
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           start,
    input  logic           clear,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   product,
    output logic           ovf,
    output logic           zero,
    output logic [W-1:0]   ula_in_1,
    output logic [W-1:0]   ula_in_2,
    output logic [1:0]     ula_opcode,
    input  logic [W-1:0]   ula_result,
    output logic [W-1:0]   barrel_src,
    output logic [SHW-1:0] barrel_shamt,
    output logic           barrel_left
);

    mul_state_t     state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   acc_q, acc_d;
    logic           ovfr_q, ovfr_d;
    logic [W-1:0]   prod_q, prod_d;
    logic           ovf_q, ovf_d;
    logic           zero_q, zero_d;
    logic [W-1:0]   w_b_shr;

    assign w_b_shr = b_q >> 1;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        ovfr_d       = ovfr_q;
        prod_d       = prod_q;
        ovf_d        = ovf_q;
        zero_d       = zero_q;
        ula_in_1     = '0;
        ula_in_2     = '0;
        ula_opcode   = ULA_ADD;
        barrel_src   = '0;
        barrel_shamt = '0;
        barrel_left  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    acc_d   = '0;
                    ovfr_d  = 1'b0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                ula_opcode = ULA_ADD;
                ula_in_1   = acc_q;
                ula_in_2   = b_q[0] ? a_q : '0;
                acc_d      = ula_result;
                if (ula_result < acc_q) begin
                    ovfr_d = 1'b1;
                end
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                ula_opcode   = ULA_BARREL;
                barrel_src   = a_q;
                barrel_shamt = SHW'(1);
                barrel_left  = 1'b1;
                a_d          = ula_result;
                b_d          = w_b_shr;
                if (a_q[W-1] && (w_b_shr != '0)) begin
                    ovfr_d = 1'b1;
                end
                // acc is final after the last ADD, so the result is published
                // on entry to DONE and is valid while done is high.
                if (w_b_shr == '0) begin
                    prod_d  = acc_q;
                    ovf_d   = ovfr_q;
                    zero_d  = (acc_q == '0);
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear) begin
            state_d = ST_IDLE;
            a_d     = a_q;
            b_d     = b_q;
            acc_d   = acc_q;
            ovfr_d  = ovfr_q;
            prod_d  = prod_q;
            ovf_d   = ovf_q;
            zero_d  = zero_q;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            ovfr_q  <= 1'b0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            ovfr_q  <= ovfr_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy    = (state_q == ST_ADD) || (state_q == ST_SHIFT);
    assign done    = (state_q == ST_DONE);
    assign product = prod_q;
    assign ovf     = ovf_q;
    assign zero    = zero_q;

endmodule

`default_nettype wire

// File: doc/ula_mul_seq.md
# ula_mul_seq

Multi-cycle sequencer that computes an unsigned W-bit truncated product by driving the shared ULA and the barrel shifter with a shift-and-add loop. It sits between the instruction control logic and the ULA datapath. It owns the ULA opcode and operand buses while `busy` is high, and it exposes a start/done handshake to the controller.

## Interface
Parameters:
- `W`, default 16: operand, product and ULA word width.
- `SHW`, default 4: barrel shift-amount width, equal to log2(W).

Ports:
- `clock`, in, 1: single clock, rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a multiply. Sampled only in IDLE.
- `clear`, in, 1: synchronous abort. The block returns to IDLE next cycle.
- `op_a`, in, W: multiplicand. Latched on an accepted start.
- `op_b`, in, W: multiplier. Latched on an accepted start.
- `busy`, out, 1: high in ADD and SHIFT.
- `done`, out, 1: one-cycle pulse in the DONE state.
- `product`, out, W: result. Held from DONE until the next accepted start.
- `ovf`, out, 1: the true product exceeded W bits. Valid with `product`.
- `zero`, out, 1: `product == 0`. Valid with `product`.
- `ula_in_1`, out, W: ULA operand 1.
- `ula_in_2`, out, W: ULA operand 2.
- `ula_opcode`, out, 2: ULA operation code. 00 = add, 01 = sub, 10 = and, 11 = pass barrel output.
- `ula_result`, in, W: ULA result, combinational from the outputs above.
- `barrel_src`, out, W: value to shift.
- `barrel_shamt`, out, SHW: shift amount.
- `barrel_left`, out, 1: 1 selects shift left.

## Operation
- Internal registers:
  - `a_reg`: shifted multiplicand.
  - `b_reg`: remaining multiplier.
  - `acc`: running product.
  - `ovf_r`: sticky overflow.
- States: IDLE, ADD, SHIFT, DONE.
- **IDLE**
  - On `start=1`: `a_reg<=op_a`, `b_reg<=op_b`, `acc<=0`, `ovf_r<=0`, next state ADD.
  - ULA outputs are driven to 0 and `ula_opcode=00`.
- **ADD**
  - Drives `ula_opcode=00`, `ula_in_1=acc`, `ula_in_2 = b_reg[0] ? a_reg : 0`.
  - Updates `acc<=ula_result`.
  - If `ula_result < acc` (unsigned wrap), sets `ovf_r`.
  - Next state SHIFT.
- **SHIFT**
  - Drives `ula_opcode=11`, `barrel_src=a_reg`, `barrel_shamt=1`, `barrel_left=1`, `ula_in_1=ula_in_2=0`.
  - Updates `a_reg<=ula_result` and `b_reg<=b_reg>>1`.
  - If `a_reg[W-1]=1` and `(b_reg>>1)!=0`, sets `ovf_r` (a live multiplicand bit is shifted out).
  - Next state DONE if `(b_reg>>1)==0`, else ADD.
- **DONE**
  - Registers `product<=acc`, `ovf<=ovf_r`, `zero<=(acc==0)`.
  - Raises `done` for one cycle.
  - Next state IDLE.
- **Iteration count**: `k = max(1, msb_index(op_b)+1)`. Every iteration is exactly one ADD plus one SHIFT, even when the multiplier bit is 0.
- **Clear**
  - `clear=1` in any state except IDLE forces IDLE next cycle.
  - No `done` pulse.
  - `product`, `ovf` and `zero` keep their previous values.
  - `clear` has priority over `start`.
- **Start while not in IDLE**: ignored. It is not queued.
- **Arithmetic**: all operations are unsigned. The product is the low W bits of `op_a*op_b`.

## Timing
- **Reset** (`resetn=0`, asynchronous):
  - State IDLE.
  - `busy=0`, `done=0`, `product=0`, `ovf=0`, `zero=1`.
  - All ULA and barrel outputs 0.
  - Internal registers cleared.
- Reset asserted mid-operation aborts immediately. The operation never resumes.
- **Latency**: for an operation with start accepted at edge 0:
  - `busy=1` for cycles 1..2k.
  - `done=1` and `product` valid in cycle 2k+1.
  - IDLE again in cycle 2k+2, where a new start is accepted.
  - Best case: 3 cycles. Worst case: 2W+1 cycles.
- **Outputs**: `busy` and `done` are decoded from registered state, with no combinational path from `start`.
- **ULA/barrel loop**: the ULA/barrel outputs are combinational from state and registers. `ula_result` must settle within the same cycle. The ULA path is purely combinational, so there is no wait state.

## Structure
- Shared package `ula_pkg`:
  - ULA opcode constants `ULA_ADD=2'b00`, `ULA_SUB=2'b01`, `ULA_AND=2'b10`, `ULA_BARREL=2'b11`.
  - State encoding typedef `mul_state_t`.
- Single module. No sub-module is needed.
- The bench instantiates the existing ULA and a left barrel shifter as the datapath model.

## Test plan
- Multiply 3 × 5: `op_a=3`, `op_b=5`, `start` for 1 cycle.
  - k=3, so `busy` is high for 6 cycles.
  - `done` in cycle 7 with `product=15`, `ovf=0`, `zero=0`.
- Multiply by zero: `op_a=0x1234`, `op_b=0`.
  - One iteration.
  - `done` in cycle 3 with `product=0`, `zero=1`, `ovf=0`.
- Overflow: `op_a=0x0100`, `op_b=0x0100`.
  - `product=0x0000`, `ovf=1`, `zero=1`, `done` in cycle 19.
  - Separately, `op_a=0xFFFF`, `op_b=2` gives `product=0xFFFE`, `ovf=1`.
- Start ignored while busy: start 7 × 9, then pulse `start` with `op_a=1`, `op_b=1` in cycle 3.
  - Single `done` with `product=63`.
  - Next start is accepted only after return to IDLE.
- Clear mid-operation: after a completed 3 × 5 (`product=15`), start 0xFF × 0xFF and assert `clear` in cycle 4.
  - Returns to IDLE with no `done` pulse.
  - `product` stays 15.
- Reset mid-operation: assert `resetn=0` asynchronously in cycle 5 of 0xFFFF × 0xFFFF.
  - Outputs immediately take their reset values: `product=0`, `zero=1`, `busy=0`.
  - A new 2 × 3 completes with `product=6`.
